// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys unrolled backwards on the fly.
// Optional AES_INV_KEY_EXPAND_EN: in_key is the cipher key and is first expanded forward to rk_10.

module aes_sbox_lane #(
  parameter bit INV = 1'b0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the GF(2^8) inverse and conveniently maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] iaff(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  assign y = INV ? ginv(iaff(a)) : aff(ginv(a));
endmodule

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NUM_LANES = 16;

`ifdef AES_INV_KEY_EXPAND_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, EXPAND} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t       st;
  logic [127:0] state_reg, key_reg;
  logic [3:0]   cnt;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // key schedule: the four SubWord S-boxes are shared by the reverse and forward directions
  logic [31:0]  w0, w1, w2, w3, t3, sw_in, sw_out, rw0;
  logic [127:0] rk_inv;
  assign {w0, w1, w2, w3} = key_reg;
  assign t3 = w3 ^ w2;
`ifdef AES_INV_KEY_EXPAND_EN
  logic [31:0]  f0;
  logic [127:0] rk_fwd;
  assign sw_in  = (st == EXPAND) ? {w3[23:0], w3[31:24]} : {t3[23:0], t3[31:24]};
  assign f0     = w0 ^ sw_out ^ {rcon(cnt + 4'd1), 24'h0};
  assign rk_fwd = {f0, f0 ^ w1, f0 ^ w1 ^ w2, f0 ^ w1 ^ w2 ^ w3};
`else
  assign sw_in = {t3[23:0], t3[31:24]};
`endif
  assign rw0    = w0 ^ sw_out ^ {rcon(cnt + 4'd1), 24'h0};
  assign rk_inv = {rw0, w1 ^ w0, w2 ^ w1, t3};

  for (genvar k = 0; k < 4; k++) begin : g_sw
    aes_sbox_lane #(.INV(1'b0)) u_sb (.a(sw_in[31-8*k -: 8]), .y(sw_out[31-8*k -: 8]));
  end

  // byte i = (row i%4, col i/4); InvShiftRows pulls row r from column c-r
  logic [NUM_LANES-1:0][7:0] isr, isb;
  logic [127:0]              ark, imc;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int R = i % 4;
    localparam int C = i / 4;
    assign isr[i] = state_reg[127-8*(R+4*((C+4-R)%4)) -: 8];
    aes_sbox_lane #(.INV(1'b1)) u_isb (.a(isr[i]), .y(isb[i]));
    assign ark[127-8*i -: 8] = isb[i] ^ rk_inv[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = ark[127-32*c -: 32];
    assign imc[127-32*c -: 32] = {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                                  m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                                  md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                                  mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
  end

  assign in_ready = (st == IDLE);
  assign busy     = (st != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          key_reg <= in_key;
`ifdef AES_INV_KEY_EXPAND_EN
          state_reg <= in_data;
          cnt       <= '0;
          st        <= EXPAND;
`else
          state_reg <= in_data ^ in_key;
          cnt       <= 4'(NR - 1);
          st        <= RUN;
`endif
        end
`ifdef AES_INV_KEY_EXPAND_EN
        EXPAND: begin
          key_reg <= rk_fwd;
          if (cnt == 4'(NR - 1)) begin
            state_reg <= state_reg ^ rk_fwd;
            st        <= RUN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`endif
        RUN: begin
          key_reg <= rk_inv;
          cnt     <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state_reg <= ark;
            out_data  <= ark;
            out_valid <= 1'b1;
            st        <= DONE;
          end else begin
            state_reg <= imc;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter; random vectors use a forward AES-128 encryption model.
module tb_aes_inv_cipher_iter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] APPB_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] APPB_PT = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_INV_KEY_EXPAND_EN
  localparam int           LAT     = 20;
  localparam logic [127:0] C1_K    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] APPB_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
  localparam int           LAT     = 10;
  localparam logic [127:0] C1_K    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] APPB_K  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
      r[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  function automatic void aes_enc(input logic [127:0] pt, input logic [127:0] key,
                                  output logic [127:0] ct, output logic [127:0] rk10);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] s;
    {w[0], w[1], w[2], w[3]} = key;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ key;
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r < 10) s = mix(s);
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    ct = s;
    rk10 = {w[40], w[41], w[42], w[43]};
  endfunction

  // drives one job from IDLE; returns at the negedge just after the accepting edge
  task automatic start_job(input logic [127:0] ct, input logic [127:0] key);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%b required 1", in_ready);
    end
    in_data = ct; in_key = key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 100 && out_valid !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_job(input string name, input int lat, input logic [127:0] exp);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, LAT);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL %s_data: got %h required %h", name, out_data, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_vector(input string name, input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] exp);
    int lat;
    start_job(ct, key);
    wait_out(lat);
    check_job(name, lat, exp);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_job(C1_CT, C1_K);
    wait_out(lat);
    check_job("bp", lat, C1_PT);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== C1_PT || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h in_ready=%b required 1/%h/0",
                 k, out_valid, out_data, in_ready, C1_PT);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    start_job(APPB_CT, APPB_K);
    repeat (2) @(negedge clk);
    in_data = C1_CT; in_key = C1_K; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_ready%0d: got %b required 0", k, in_ready);
      end
    end
    in_valid = 1'b0;
    wait_out(lat);
    check_job("ignore", lat + 5, APPB_PT);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    start_job(C1_CT, C1_K);
    repeat (LAT - 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b required 1", in_ready); end
    test_vector("after_abort", C1_CT, C1_K, C1_PT);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt[4], kin[4], ct[4];
    logic [127:0] key, rk10;
    int  sent = 0;
    int  rcv  = 0;
    int  cyc  = 0;
    bit  pend;
    for (int j = 0; j < 4; j++) begin
      pt[j]  = {$urandom, $urandom, $urandom, $urandom};
      key    = {$urandom, $urandom, $urandom, $urandom};
      aes_enc(pt[j], key, ct[j], rk10);
`ifdef AES_INV_KEY_EXPAND_EN
      kin[j] = key;
`else
      kin[j] = rk10;
`endif
    end
    @(negedge clk);
    in_data = ct[0]; in_key = kin[0]; in_valid = 1'b1;
    while (rcv < 4 && cyc < 400) begin
      pend = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (pend) begin
        sent++;
        if (sent < 4) begin in_data = ct[sent]; in_key = kin[sent]; end
        else in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== pt[rcv] || sent !== rcv + 1) begin
          errors++;
          $display("FAIL b2b_%0d: got %h (accepted %0d) required %h (accepted %0d)",
                   rcv, out_data, sent, pt[rcv], rcv + 1);
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rcv !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results required 4", rcv);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vector("c1", C1_CT, C1_K, C1_PT);
    test_vector("appb", APPB_CT, APPB_K, APPB_PT);
    test_backpressure();
    test_ignore_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
